// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer. Adds two WIDTH-bit operands plus a carry-in
//   using a single 1-bit full_adder cell, one bit per clock, LSB first.
//   The block owns the operand shift registers, the carry flop, the bit
//   counter and the start/busy/done handshake.
//
// Parameters
//   WIDTH  operand/sum width in bits (1..64)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      add request, honoured only when not busy
//   a, b   in   WIDTH  operands, captured on an accepted start
//   cin    in   1      carry-in, captured on an accepted start
//   busy   out  1      high while bits are being added
//   done   out  1      one-cycle pulse: s/cout were just updated
//   s      out  WIDTH  registered sum, held until the next done
//   cout   out  1      registered carry-out, held until the next done
// -----------------------------------------------------------------------------

// 1-bit full adder cell shared by the sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_fa_s;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  // The only adder in the design; it always sees the current LSBs and carry.
  full_adder u_fa (
    .a    (r_sh_a[0]),
    .b    (r_sh_b[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_nxt = w_fa_s;
    end else begin : g_sum_wn
      assign w_sum_nxt = {w_fa_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // A new request can be taken in IDLE or straight out of DONE (back-to-back).
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

  // NOTE: every signal driven in always_comb gets a default first so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum_sh <= '0;
      r_s      <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_sh_a   <= a;
      r_sh_b   <= b;
      r_carry  <= cin;
      r_cnt    <= '0;
      r_sum_sh <= '0;
    end else if (r_state == RUN) begin
      r_sh_a   <= r_sh_a >> 1;
      r_sh_b   <= r_sh_b >> 1;
      r_carry  <= w_fa_cout;
      r_sum_sh <= w_sum_nxt;
      r_cnt    <= r_cnt + CW'(1);
      // Outputs change only on the last bit, so the previous result stays
      // visible for the whole addition.
      if (w_last) begin
        r_s    <= w_sum_nxt;
        r_cout <= w_fa_cout;
      end
    end
  end

  // Pure state decodes: no combinational path from start to busy/done.
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed self-checking bench for serial_add_ctrl at WIDTH=8: reset state,
//   latency, hand-computed sums, result hold during an addition, start
//   ignored while busy, mid-addition reset, back-to-back starts and a short
//   sweep against an a+b+cin model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  int vectors     = 0;
  int miscompares = 0;

  // Result the DUT should currently be showing on s/cout.
  logic [W-1:0] last_s    = '0;
  logic         last_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one add (from IDLE or DONE) and wait for its done pulse.
  // poke: pulse start with a=0x11 in the middle of the addition.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec, input bit poke);
    int lat;
    int hold_bad;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Captured copies only: scramble the live inputs.
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    check({tag, " busy after accept"}, busy, 1);
    lat      = 0;
    hold_bad = 0;
    while (!done && lat < 20) begin
      if (s !== last_s || cout !== last_cout) hold_bad++;
      if (poke && lat == 3) begin
        start = 1'b1;
        a     = 8'h11;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, W);
    check({tag, " hold during run"}, hold_bad, 0);
    check({tag, " s"}, s, es);
    check({tag, " cout"}, cout, ec);
    last_s    = es;
    last_cout = ec;
  endtask

  // Leave DONE without a new start and confirm done is a single-cycle pulse.
  task automatic to_idle(input string tag);
    start = 1'b0;
    tick();
    check({tag, " done pulse width"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    logic [W:0]   sum;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset s", s, 0);
    check("reset cout", cout, 0);
    rst_n = 1'b1;
    tick();

    // Zero operands.
    run_add("t2 zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    to_idle("t2");

    // Full carry ripple and an ordinary sum.
    run_add("t3 ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    to_idle("t3a");
    run_add("t3 3c+0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    to_idle("t3b");

    // Carry-in ripples all the way; 0x4B must hold during the run.
    run_add("t4 a5+5a+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    to_idle("t4");

    // start pulsed mid-run with a=0x11 must be ignored: 0x12+0x34+0=0x46.
    run_add("t5 ignore start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    to_idle("t5");

    // Establish a nonzero result, then reset in the middle of an addition.
    run_add("t1 pre", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
    to_idle("t1 pre");
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("t1 mid-run reset busy", busy, 0);
    check("t1 mid-run reset done", done, 0);
    check("t1 mid-run reset s", s, 0);
    check("t1 mid-run reset cout", cout, 0);
    rst_n     = 1'b1;
    last_s    = '0;
    last_cout = 1'b0;
    tick();
    run_add("t1 after reset", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Back-to-back: start issued while in DONE.
    run_add("t6 80+80 chained", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);

    // Chained sweep against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_add($sformatf("sweep%0d", i), ra, rb, rc, sum[W-1:0], sum[W], 1'b0);
    end
    to_idle("sweep end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
